control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//   Control unit of the 8-bit computer. Owns the PC, decodes the instruction word, and drives
//   load/select/ALU-op/write strobes to the regA/regB/ALU/data-memory datapath.
//   Keeps a registered status-flag word and resolves conditional jumps.
//   Provides a run/halt/single-step debug FSM so benches can freeze and step the machine.
//   Sits between the instruction memory IM (combinational read, addressed by pc) and the datapath.
// PARAMETERS
//   PC_W   8   program-counter / IM address width
//   OP_W   7   opcode field width, instr[LIT_W+OP_W-1:LIT_W]
//   LIT_W  8   literal field width, instr[LIT_W-1:0]
//   CNT_W  16  retired-instruction counter width
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous, active-high reset
//   instr      in   OP_W+LIT_W   IM read data for the current pc
//   alu_flags  in   4            {Z,N,C,V} from the ALU for the current instruction
//   dbg_halt   in   1            level: halt after the current instruction retires
//   dbg_step   in   1            pulse: retire exactly one instruction while debug-halted
//   pc         out  PC_W         IM address
//   lit        out  LIT_W        literal field, passed through to the datapath
//   la, lb     out  1            regA / regB load enables
//   sa, sb     out  2            ALU operand-A / operand-B mux selects
//   sop        out  3            ALU operation
//   w          out  1            data-memory write enable
//   exec       out  1            an instruction retires at this clk edge
//   halted     out  1            FSM is in HALT
//   illegal    out  1            sticky: an undefined opcode has been executed
//   instr_cnt  out  CNT_W        number of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (rst at the edge): pc=0, flags=0, illegal=0, instr_cnt=0, state=RESET.
//     All strobes la/lb/w/exec are 0; sa/sb/sop are 0. rst dominates every other input.
//   - FSM:
//       RESET -> RUN unconditionally after 1 cycle.
//       RUN -> HALT when HLT retires, or when dbg_halt=1 at the retire edge.
//       HALT(dbg) -> HALT(dbg) after each dbg_step retire.
//       HALT(dbg) -> RUN when dbg_halt=0.
//       HALT(hlt) exits only on rst.
//   - Execute: exec=1 in RUN, and in HALT(dbg) during a cycle with dbg_step=1.
//     When exec=0, la/lb/w are forced to 0 and pc, flags and instr_cnt hold.
//   - Single-cycle instructions: strobes are decoded combinationally from instr in the same
//     cycle. Registers update at the next edge. Latency is 1 clk per instruction.
//   - pc update when exec=1: pc <= take ? lit : pc+1. Wraps modulo 2^PC_W (0xFF -> 0x00).
//   - flags <= alu_flags at an exec edge only if the decoded upd_flags=1 (ALU ops, CMP).
//     Otherwise flags hold.
//   - Jump conditions use the registered flags, i.e. the result of the last flag-setting
//     instruction, never the same-cycle ALU output:
//       JMP always, JEQ Z, JNE !Z, JGT !N&!Z, JGE !N, JLT N, JLE N|Z, JCR C, JOV V.
//   - HLT retires as a NOP with exec=1, sets halted, and pc stays at the HLT address.
//     dbg_step is ignored in HALT(hlt).
//   - Undefined opcode: NOP (no strobes), sets illegal (sticky until rst), pc+1.
//   - Simultaneous events:
//       a jump retiring with dbg_halt=1 takes the jump, then halts;
//       dbg_step in RUN is ignored;
//       dbg_step and dbg_halt falling together: the step retires, then RUN.
//   - instr_cnt increments on every exec edge, including HLT and illegal opcodes.
// STRUCTURE
//   - Shared package cpu_pkg:
//       opcode localparams (OP_* encodings);
//       sop and sa/sb select encodings;
//       flag indices FLG_Z/N/C/V;
//       ctrl_t {la,lb,sa,sb,sop,w,upd_flags,jcond[3:0],is_hlt,legal};
//       jcond encodings.
//   - Sub-module instr_decoder: purely combinational opcode -> ctrl_t.
//   - This module holds only the FSM, pc, flags, counter and gating.
// TESTING
//   - T1: rst for 2 clks; IM = MOV A,42 ; MOV B,123
//       -> one RESET cycle with pc=0, exec=0;
//       -> then pc=0 la=1 lit=42, pc=1 lb=1 lit=123, pc=2; instr_cnt=2.
//   - T2: CMP A,B at pc=4 with alu_flags Z=1, then JEQ 0x10 at pc=5 -> pc=0x10.
//       Repeat with Z=0 -> pc=6.
//       A same-cycle Z=1 on the JEQ itself must not change the outcome.
//   - T3: JMP 0xFF, then NOP at 0xFF -> pc=0xFF, then 0x00. No illegal flag.
//   - T4: dbg_halt=1 while retiring pc=3
//       -> halted=1, pc=4 frozen, la/lb/w=0 for 5 clks;
//       -> one dbg_step pulse: exactly one retire, pc=5, halted stays 1;
//       -> dbg_halt=0: RUN resumes at pc=5.
//   - T5: HLT at pc=7
//       -> halted=1, pc=7 held; dbg_step pulses cause no retire;
//       -> rst mid-halt: pc=0, flags=0, halted=0, illegal=0 after the RESET cycle.
//   - T6: opcode 7'h7F at pc=2 -> no strobes, illegal=1, pc=3; illegal stays 1 through 10
//       further instructions.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer control path: field widths, opcodes,
// ALU selects, flag positions and the decoded control word.
package cpu_pkg;
  localparam int PC_W    = 8;
  localparam int OP_W    = 7;
  localparam int LIT_W   = 8;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = OP_W + LIT_W;

  localparam logic [OP_W-1:0] OP_NOP     = 7'h00;
  localparam logic [OP_W-1:0] OP_MOV_A_L = 7'h01;
  localparam logic [OP_W-1:0] OP_MOV_B_L = 7'h02;
  localparam logic [OP_W-1:0] OP_MOV_A_B = 7'h03;
  localparam logic [OP_W-1:0] OP_MOV_B_A = 7'h04;
  localparam logic [OP_W-1:0] OP_ADD     = 7'h08;
  localparam logic [OP_W-1:0] OP_SUB     = 7'h09;
  localparam logic [OP_W-1:0] OP_AND     = 7'h0A;
  localparam logic [OP_W-1:0] OP_OR      = 7'h0B;
  localparam logic [OP_W-1:0] OP_XOR     = 7'h0C;
  localparam logic [OP_W-1:0] OP_ADD_L   = 7'h0D;
  localparam logic [OP_W-1:0] OP_CMP     = 7'h10;
  localparam logic [OP_W-1:0] OP_CMP_L   = 7'h11;
  localparam logic [OP_W-1:0] OP_STORE   = 7'h18;
  localparam logic [OP_W-1:0] OP_JMP     = 7'h20;
  localparam logic [OP_W-1:0] OP_JEQ     = 7'h21;
  localparam logic [OP_W-1:0] OP_JNE     = 7'h22;
  localparam logic [OP_W-1:0] OP_JGT     = 7'h23;
  localparam logic [OP_W-1:0] OP_JGE     = 7'h24;
  localparam logic [OP_W-1:0] OP_JLT     = 7'h25;
  localparam logic [OP_W-1:0] OP_JLE     = 7'h26;
  localparam logic [OP_W-1:0] OP_JCR     = 7'h27;
  localparam logic [OP_W-1:0] OP_JOV     = 7'h28;
  localparam logic [OP_W-1:0] OP_HLT     = 7'h3F;

  localparam logic [2:0] SOP_ADD = 3'd0;
  localparam logic [2:0] SOP_SUB = 3'd1;
  localparam logic [2:0] SOP_AND = 3'd2;
  localparam logic [2:0] SOP_OR  = 3'd3;
  localparam logic [2:0] SOP_XOR = 3'd4;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_LIT  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  // alu_flags is {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam logic [3:0] JC_NONE   = 4'd0;
  localparam logic [3:0] JC_ALWAYS = 4'd1;
  localparam logic [3:0] JC_EQ     = 4'd2;
  localparam logic [3:0] JC_NE     = 4'd3;
  localparam logic [3:0] JC_GT     = 4'd4;
  localparam logic [3:0] JC_GE     = 4'd5;
  localparam logic [3:0] JC_LT     = 4'd6;
  localparam logic [3:0] JC_LE     = 4'd7;
  localparam logic [3:0] JC_CR     = 4'd8;
  localparam logic [3:0] JC_OV     = 4'd9;

  typedef struct packed {
    logic       la;
    logic       lb;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] sop;
    logic       w;
    logic       upd_flags;
    logic [3:0] jcond;
    logic       is_hlt;
    logic       legal;
  } ctrl_t;
endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer, instruction memory, datapath and debug host.
// master is the sequencer side, slave the surrounding machine.
interface control_sequencer_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         alu_flags;
  logic               dbg_halt;
  logic               dbg_step;
  logic [PC_W-1:0]    pc;
  logic [LIT_W-1:0]   lit;
  logic               la;
  logic               lb;
  logic [1:0]         sa;
  logic [1:0]         sb;
  logic [2:0]         sop;
  logic               w;
  logic               exec;
  logic               halted;
  logic               illegal;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  instr, alu_flags, dbg_halt, dbg_step,
    output pc, lit, la, lb, sa, sb, sop, w, exec, halted, illegal, instr_cnt
  );

  modport slave (
    output instr, alu_flags, dbg_halt, dbg_step,
    input  pc, lit, la, lb, sa, sb, sop, w, exec, halted, illegal, instr_cnt
  );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational opcode decode into the control word; unknown opcodes
// decode to a strobe-free NOP with legal cleared.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);
  always_comb begin
    ctrl       = '0;
    ctrl.legal = 1'b1;
    case (opcode)
      OP_NOP:     ctrl.legal = 1'b1;
      OP_MOV_A_L: begin ctrl.la = 1'b1; ctrl.sa = SEL_ZERO; ctrl.sb = SEL_LIT; end
      OP_MOV_B_L: begin ctrl.lb = 1'b1; ctrl.sa = SEL_ZERO; ctrl.sb = SEL_LIT; end
      OP_MOV_A_B: begin ctrl.la = 1'b1; ctrl.sa = SEL_ZERO; ctrl.sb = SEL_B; end
      OP_MOV_B_A: begin ctrl.lb = 1'b1; ctrl.sa = SEL_A; ctrl.sb = SEL_ZERO; end
      OP_ADD:   begin ctrl.la = 1'b1; ctrl.sb = SEL_B; ctrl.sop = SOP_ADD; ctrl.upd_flags = 1'b1; end
      OP_SUB:   begin ctrl.la = 1'b1; ctrl.sb = SEL_B; ctrl.sop = SOP_SUB; ctrl.upd_flags = 1'b1; end
      OP_AND:   begin ctrl.la = 1'b1; ctrl.sb = SEL_B; ctrl.sop = SOP_AND; ctrl.upd_flags = 1'b1; end
      OP_OR:    begin ctrl.la = 1'b1; ctrl.sb = SEL_B; ctrl.sop = SOP_OR;  ctrl.upd_flags = 1'b1; end
      OP_XOR:   begin ctrl.la = 1'b1; ctrl.sb = SEL_B; ctrl.sop = SOP_XOR; ctrl.upd_flags = 1'b1; end
      OP_ADD_L: begin ctrl.la = 1'b1; ctrl.sb = SEL_LIT; ctrl.sop = SOP_ADD; ctrl.upd_flags = 1'b1; end
      // compares run a subtract for the flags only; no register is loaded
      OP_CMP:   begin ctrl.sb = SEL_B;   ctrl.sop = SOP_SUB; ctrl.upd_flags = 1'b1; end
      OP_CMP_L: begin ctrl.sb = SEL_LIT; ctrl.sop = SOP_SUB; ctrl.upd_flags = 1'b1; end
      OP_STORE: begin ctrl.w = 1'b1; ctrl.sa = SEL_A; ctrl.sb = SEL_ZERO; end
      OP_JMP:   ctrl.jcond = JC_ALWAYS;
      OP_JEQ:   ctrl.jcond = JC_EQ;
      OP_JNE:   ctrl.jcond = JC_NE;
      OP_JGT:   ctrl.jcond = JC_GT;
      OP_JGE:   ctrl.jcond = JC_GE;
      OP_JLT:   ctrl.jcond = JC_LT;
      OP_JLE:   ctrl.jcond = JC_LE;
      OP_JCR:   ctrl.jcond = JC_CR;
      OP_JOV:   ctrl.jcond = JC_OV;
      OP_HLT:   ctrl.is_hlt = 1'b1;
      default:  ctrl.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// Control unit: pc, registered flags, retire counter and the run/halt/step FSM.
// state     | meaning
// ST_RESET  | one idle cycle after rst, nothing retires
// ST_RUN    | one instruction retires per clk
// ST_HLT_D  | debug halt, retires only on dbg_step
// ST_HLT_H  | HLT executed, frozen until rst
module control_sequencer
  import cpu_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);
  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HLT_D, ST_HLT_H} state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [3:0]       flags;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cnt;
  ctrl_t            ctrl;
  logic             exec;
  logic             take;

  instr_decoder u_dec (
    .opcode (bus.instr[INSTR_W-1:LIT_W]),
    .ctrl   (ctrl)
  );

  assign exec = !rst && (state == ST_RUN || (state == ST_HLT_D && bus.dbg_step));

  // jumps resolve against the last flag-setting instruction, never same-cycle ALU flags
  always_comb begin
    case (ctrl.jcond)
      JC_ALWAYS: take = 1'b1;
      JC_EQ:     take = flags[FLG_Z];
      JC_NE:     take = !flags[FLG_Z];
      JC_GT:     take = !flags[FLG_N] && !flags[FLG_Z];
      JC_GE:     take = !flags[FLG_N];
      JC_LT:     take = flags[FLG_N];
      JC_LE:     take = flags[FLG_N] || flags[FLG_Z];
      JC_CR:     take = flags[FLG_C];
      JC_OV:     take = flags[FLG_V];
      default:   take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      halted  <= 1'b0;
      pc      <= '0;
      flags   <= '0;
      illegal <= 1'b0;
      cnt     <= '0;
    end else begin
      if (exec) begin
        if (!ctrl.is_hlt) pc <= take ? PC_W'(bus.instr[LIT_W-1:0]) : pc + PC_W'(1);
        if (ctrl.upd_flags) flags <= bus.alu_flags;
        if (!ctrl.legal) illegal <= 1'b1;
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        ST_RESET: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
        ST_RUN, ST_HLT_D: begin
          if (exec && ctrl.is_hlt) begin
            state  <= ST_HLT_H;
            halted <= 1'b1;
          end else if (bus.dbg_halt) begin
            state  <= ST_HLT_D;
            halted <= 1'b1;
          end else begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_HLT_H;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc        = pc;
  assign bus.lit       = bus.instr[LIT_W-1:0];
  assign bus.exec      = exec;
  assign bus.la        = exec && ctrl.la;
  assign bus.lb        = exec && ctrl.lb;
  assign bus.w         = exec && ctrl.w;
  assign bus.sa        = exec ? ctrl.sa : '0;
  assign bus.sb        = exec ? ctrl.sb : '0;
  assign bus.sop       = exec ? ctrl.sop : '0;
  assign bus.halted    = halted;
  assign bus.illegal   = illegal;
  assign bus.instr_cnt = cnt;
endmodule
